mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared 32-bit memory port behind the CPU memory bus, which covers internal 64KB RAM and external memory.
- Lets NUM_MASTERS requesters (CPU fetch, CPU data, future DMA) share one memory port.
- Registers each winning request, drives one read or write, waits for mem_ready, and returns data, ack and error to the winner.
- A bus-timeout counter catches slaves that never assert mem_ready.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8)
- IDX_W, 1, grant index width; must equal clog2(NUM_MASTERS), minimum 1
- TIMEOUT_CYCLES, 255, wait cycles in BUSY before the bus error fires; 0 disables the timeout
- ERR_DATA, 32'hDEADBEEF, m_rdata value returned on timeout

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request, level, held until its ack
- m_we  in  NUM_MASTERS  per-master 1=write, 0=read
- m_addr  in  NUM_MASTERS*32  per-master byte address, master i at bits [32*i+31:32*i]
- m_wdata  in  NUM_MASTERS*32  per-master write data, same packing
- m_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot
- m_err  out  1  qualifies m_ack: transaction timed out
- m_rdata  out  32  read data, valid while any m_ack bit is high
- mem_addr  out  32  slave address
- mem_wdata  out  32  slave write data
- mem_read  out  1  slave read strobe
- mem_write  out  1  slave write strobe
- mem_ready  in  1  slave completion
- mem_rdata  in  32  slave read data, sampled when mem_ready=1
- grant_idx  out  IDX_W  index of the current or last owner
- busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (asynchronous, any state, including mid-transaction): state=IDLE; all outputs 0; rr_last=NUM_MASTERS-1, so master 0 wins first; timeout counter 0. An aborted transaction is never acked.
- FSM state IDLE:
  - If any m_req bit is set at a rising edge, pick the winner: first set bit scanning rr_last+1, rr_last+2, ... modulo NUM_MASTERS.
  - Register the winner's addr, wdata and we; set grant_idx and rr_last to the winner; go to BUSY.
  - With no request, stay in IDLE.
- FSM state BUSY:
  - mem_read=!we_q and mem_write=we_q, held constant with mem_addr/mem_wdata for the whole state.
  - Timeout counter increments each cycle mem_ready=0.
  - If mem_ready=1: capture mem_rdata, go to DONE, m_err=0.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: go to DONE, m_rdata=ERR_DATA, m_err=1.
  - Strobes deassert on entry to DONE. mem_ready is sampled only in BUSY and ignored elsewhere.
- FSM state DONE:
  - m_ack[grant_idx]=1 for exactly one cycle; m_rdata is valid (written-back data is don't-care on writes, but registered anyway).
  - Counter clears; go to IDLE.
- Master rule: drop m_req before the first IDLE sampling edge after ack. A request still high there counts as a new request.
- Latency: request sampled at edge E0 leads to strobes in cycle E0..E1; with zero wait states the ack is in cycle E1..E2. That gives 2 cycles plus slave wait states, and a maximum throughput of one transaction per 3 cycles.
- Requester inputs change freely outside IDLE; they are ignored while BUSY or DONE.
- m_req bits at index >= NUM_MASTERS do not exist. NUM_MASTERS=1 degenerates to a registered pass-through.
- No other ordering or fairness guarantee beyond round-robin: every requester holding m_req is served within NUM_MASTERS transactions.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2
  - ADDR_W=32, DATA_W=32
  - default ERR_DATA
- Sub-module rr_pick: combinational round-robin selector; inputs req vector and last index; outputs valid and winner index. Reused later by the interrupt controller.
- Top level holds the FSM, capture registers and timeout counter.

Test Plan:
- Single read: m_req=2'b01, m_we=0, addr 0x00000010; slave returns ready in the first BUSY cycle with rdata 0x2002000A. Expect mem_read high one cycle, then m_ack=2'b01 and m_rdata=0x2002000A two cycles after the request edge, m_err=0.
- Write with wait states: master 1 writes 0xCAFEF00D to 0x00010004; mem_ready is held low 3 cycles. Expect mem_write, mem_addr and mem_wdata stable for 4 cycles, then m_ack=2'b10 one cycle, grant_idx=1.
- Contention: both masters request continuously, re-raising m_req after each ack. Expect the grant sequence 0,1,0,1; neither is acked twice in a row.
- Timeout: TIMEOUT_CYCLES=4, mem_ready stuck low. Expect mem_read high exactly 4 cycles, then m_ack with m_err=1 and m_rdata=0xDEADBEEF; the next request is served normally.
- Reset mid-BUSY: assert rst_n=0 during the wait state. Expect strobes, busy and m_ack at 0 immediately (asynchronous); after release, master 0 wins first even if master 1 also requests.
- Stale request: master keeps m_req high one cycle past the ack. Expect a second full transaction to the same address, confirming the documented handshake rule.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, bus widths and default error data for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] DEF_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit after last (modulo N)
module rr_pick #(
  parameter int N = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  assign valid = |req;
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      int c;
      c = (int'(last) + i) % N;
      idx = req[c[IDX_W-1:0]] ? c[IDX_W-1:0] : idx;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and single-transaction sequencer for the shared memory port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);
  state_t state;
  logic [IDX_W-1:0] rr_last, win;
  logic valid, sel_we, time_up;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [31:0] cnt;
  logic [NUM_MASTERS-1:0] ack_vec;
  rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req(m_req),
    .last(rr_last),
    .valid(valid),
    .idx(win)
  );
  assign time_up = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
  always_comb begin
    sel_addr = '0;
    sel_wdata = '0;
    sel_we = 1'b0;
    ack_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_addr = IDX_W'(i) == win ? m_addr[ADDR_W*i +: ADDR_W] : sel_addr;
      sel_wdata = IDX_W'(i) == win ? m_wdata[DATA_W*i +: DATA_W] : sel_wdata;
      sel_we = IDX_W'(i) == win ? m_we[i] : sel_we;
      ack_vec[i] = IDX_W'(i) == grant_idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      m_ack <= '0;
      m_err <= 1'b0;
      m_rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      grant_idx <= '0;
      busy <= 1'b0;
      rr_last <= IDX_W'(NUM_MASTERS - 1);
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (valid) begin
          state <= ST_BUSY;
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_read <= !sel_we;
          mem_write <= sel_we;
          grant_idx <= win;
          rr_last <= win;
          busy <= 1'b1;
        end
        ST_BUSY: begin
          cnt <= mem_ready ? cnt : cnt + 32'd1;
          if (mem_ready || time_up) begin
            state <= ST_DONE;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            m_ack <= ack_vec;
            m_err <= !mem_ready;
            m_rdata <= mem_ready ? mem_rdata : ERR_DATA;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          m_ack <= '0;
          m_err <= 1'b0;
          cnt <= '0;
          busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven plus directed-sequence self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] rdata;
    int waits;
    int strobes;
    logic grant;
    logic err;
    logic [31:0] exp_rdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] m_req = '0;
  logic [1:0] m_we = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0] m_ack;
  logic m_err;
  logic [31:0] m_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_read;
  logic mem_write;
  logic mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [0:0] grant_idx;
  logic busy;
  int checks = 0;
  int errors = 0;
  vec_t vecs[9];
  mem_bus_arbiter #(
    .NUM_MASTERS(2),
    .IDX_W(1),
    .TIMEOUT_CYCLES(4),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_ack(m_ack),
    .m_err(m_err),
    .m_rdata(m_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .grant_idx(grant_idx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input vec_t v, input int k);
    logic g, ew, done;
    logic [31:0] ea, ewd;
    int n, s;
    g = v.grant;
    ew = v.we[g];
    ea = g ? v.addr1 : v.addr0;
    ewd = g ? v.wdata1 : v.wdata0;
    @(negedge clk);
    m_req = v.req;
    m_we = v.we;
    m_addr = {v.addr1, v.addr0};
    m_wdata = {v.wdata1, v.wdata0};
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d busy", k), busy, 1);
    chk($sformatf("v%0d grant_idx", k), grant_idx, g);
    chk($sformatf("v%0d mem_addr", k), mem_addr, ea);
    chk($sformatf("v%0d mem_wdata", k), mem_wdata, ewd);
    chk($sformatf("v%0d mem_read", k), mem_read, !ew);
    chk($sformatf("v%0d mem_write", k), mem_write, ew);
    m_req = '0;
    m_we = ~v.we;
    m_addr = '1;
    n = 0;
    s = 1;
    done = 1'b0;
    while (!done && n < 12) begin
      mem_ready = n == v.waits;
      mem_rdata = v.rdata;
      @(posedge clk);
      #1;
      if (m_ack != 2'b00) done = 1'b1;
      else begin
        if (mem_read == !ew && mem_write == ew && mem_addr == ea && mem_wdata == ewd) s++;
        n++;
      end
    end
    chk($sformatf("v%0d ack_seen", k), done, 1);
    chk($sformatf("v%0d m_ack", k), m_ack, g ? 2'b10 : 2'b01);
    chk($sformatf("v%0d m_err", k), m_err, v.err);
    chk($sformatf("v%0d m_rdata", k), m_rdata, v.exp_rdata);
    chk($sformatf("v%0d strobe_cycles", k), s, v.strobes);
    chk($sformatf("v%0d strobes_off", k), {mem_read, mem_write}, 0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d ack_pulse", k), m_ack, 0);
    chk($sformatf("v%0d idle", k), busy, 0);
  endtask
  initial begin
    vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 32'h2002000A, 0, 1, 1'b0, 1'b0, 32'h2002000A};
    vecs[1] = '{2'b10, 2'b10, 32'h0, 32'h00010004, 32'h0, 32'hCAFEF00D, 32'h0, 3, 4, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 32'hA1, 0, 1, 1'b0, 1'b0, 32'hA1};
    vecs[3] = '{2'b11, 2'b11, 32'h104, 32'h204, 32'h11, 32'h22, 32'hA2, 1, 2, 1'b1, 1'b0, 32'hA2};
    vecs[4] = '{2'b11, 2'b01, 32'h108, 32'h208, 32'h33, 32'h44, 32'hA3, 0, 1, 1'b0, 1'b0, 32'hA3};
    vecs[5] = '{2'b11, 2'b00, 32'h10C, 32'h20C, 32'h0, 32'h0, 32'hA4, 2, 3, 1'b1, 1'b0, 32'hA4};
    vecs[6] = '{2'b01, 2'b00, 32'h300, 32'h0, 32'h0, 32'h0, 32'h55, 100, 4, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[7] = '{2'b10, 2'b00, 32'h0, 32'h400, 32'h0, 32'h0, 32'h12345678, 0, 1, 1'b1, 1'b0, 32'h12345678};
    vecs[8] = '{2'b11, 2'b00, 32'h500, 32'h600, 32'h0, 32'h0, 32'h9, 0, 1, 1'b0, 1'b0, 32'h9};
    #1;
    chk("rst busy", busy, 0);
    chk("rst strobes", {mem_read, mem_write}, 0);
    chk("rst m_ack", m_ack, 0);
    chk("rst grant_idx", grant_idx, 0);
    chk("rst m_rdata", m_rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) run(vecs[k], k);
    @(negedge clk);
    m_req = 2'b01;
    m_we = 2'b00;
    m_addr = {32'h900, 32'h800};
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst busy", busy, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst read", mem_read, 0);
    chk("async_rst busy", busy, 0);
    chk("async_rst ack", m_ack, 0);
    m_req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst grant", grant_idx, 0);
    chk("post_rst addr", mem_addr, 32'h800);
    chk("post_rst busy", busy, 1);
    m_req = 2'b00;
    mem_ready = 1'b1;
    mem_rdata = 32'h77;
    @(posedge clk);
    #1;
    chk("post_rst ack", m_ack, 2'b01);
    chk("post_rst rdata", m_rdata, 32'h77);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    m_req = 2'b01;
    m_addr = {32'h0, 32'hABC0};
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1;
    @(posedge clk);
    #1;
    chk("stale ack1", m_ack, 2'b01);
    @(posedge clk);
    #1;
    chk("stale idle", busy, 0);
    @(posedge clk);
    #1;
    chk("stale busy2", busy, 1);
    chk("stale read2", mem_read, 1);
    chk("stale addr2", mem_addr, 32'hABC0);
    m_req = 2'b00;
    mem_rdata = 32'h2;
    @(posedge clk);
    #1;
    chk("stale ack2", m_ack, 2'b01);
    chk("stale rdata2", m_rdata, 32'h2);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("final idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
